lsu_mem_stage: RTL and testbench

//   Load/store unit downstream of the ALU: takes the ALU result as the effective

---
 rtl/lsu_mem_stage.sv | 193 +++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one data-memory access per start pulse over a req/ack
// handshake, with lane steering for stores and sign/zero extension for loads.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    localparam logic [7:0] CntMax = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        we_q, we_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [3:0]  mbe_q, mbe_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        fault_q, fault_d;

    logic        illegal;
    logic        mis_new;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Decode of the launching instruction; stores only allow B/H/W.
    always_comb begin
        illegal = 1'b1;
        unique case (funct3_i)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = is_store_i;
            default:                illegal = 1'b1;
        endcase
        mis_new = !illegal &&
                  (((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)));
    end

    always_comb begin
        lane_wdata = wdata_i;
        lane_be    = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                lane_wdata = {4{wdata_i[7:0]}};
                lane_be    = 4'b0001 << addr_i[1:0];
            end
            2'b01: begin
                lane_wdata = {2{wdata_i[15:0]}};
                lane_be    = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_wdata = wdata_i;
                lane_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        byte_sel = mem_rdata_i[7:0];
        case (addr_lo_q)
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel = addr_lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'b0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'b0, half_sel};
            default: load_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        we_d      = we_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        mbe_d     = mbe_q;
        rdata_d   = rdata_q;
        mis_d     = mis_q;
        fault_d   = fault_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    funct3_d  = funct3_i;
                    addr_lo_d = addr_i[1:0];
                    we_d      = is_store_i;
                    maddr_d   = {addr_i[31:2], 2'b00};
                    mwdata_d  = lane_wdata;
                    mbe_d     = lane_be;
                    cnt_d     = 8'd0;
                    if (illegal || mis_new) begin
                        // Error-only path: complete without touching memory.
                        state_d = StResp;
                        rdata_d = 32'b0;
                        fault_d = illegal;
                        mis_d   = mis_new;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_ack_i) begin
                    state_d = StResp;
                    rdata_d = we_q ? 32'b0 : load_ext;
                    fault_d = 1'b0;
                    mis_d   = 1'b0;
                end else if (cnt_q == CntMax) begin
                    state_d = StResp;
                    rdata_d = 32'b0;
                    fault_d = 1'b1;
                    mis_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            funct3_q  <= 3'b0;
            addr_lo_q <= 2'b0;
            we_q      <= 1'b0;
            maddr_q   <= 32'b0;
            mwdata_q  <= 32'b0;
            mbe_q     <= 4'b0;
            rdata_q   <= 32'b0;
            mis_q     <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            we_q      <= we_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            mbe_q     <= mbe_d;
            rdata_q   <= rdata_d;
            mis_q     <= mis_d;
            fault_q   <= fault_d;
        end
    end

    assign mem_req_o    = (state_q == StReq);
    assign busy_o       = (state_q == StReq);
    assign done_o       = (state_q == StResp);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = maddr_q;
    assign mem_wdata_o  = mwdata_q;
    assign mem_be_o     = mbe_q;
    assign rdata_o      = rdata_q;
    assign misaligned_o = mis_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: expected completions are queued at launch and checked
// by a monitor when done fires; bus-side behaviour is checked inline per scenario.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done, misaligned, fault;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic [31:0] rd;
        logic        mis;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    lsu_mem_stage #(.TIMEOUT_CYCLES(64)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .is_store_i  (is_store),
        .funct3_i    (funct3),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .busy_o      (busy),
        .done_o      (done),
        .rdata_o     (rdata),
        .misaligned_o(misaligned),
        .fault_o     (fault),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got rdata=%h mis=%b fault=%b, none expected",
                         rdata, misaligned, fault);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rdata, misaligned, fault} !== {mon_e.rd, mon_e.mis, mon_e.flt}) begin
                    miscompares++;
                    $display("FAIL result: got rdata=%h mis=%b fault=%b, want rdata=%h mis=%b fault=%b",
                             rdata, misaligned, fault, mon_e.rd, mon_e.mis, mon_e.flt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called #1 after an edge with the DUT idle; returns #1 after the sampling edge.
    task automatic launch(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0; is_store = 1'b0; funct3 = 3'b0; addr = 32'b0; wdata = 32'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, done, mem_req, mem_we, misaligned, fault, rdata, mem_addr, mem_wdata, mem_be}
            !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b req=%b we=%b rdata=%h addr=%h be=%b, want all 0",
                     busy, done, mem_req, mem_we, rdata, mem_addr, mem_be);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [7];
        logic [31:0] a  [7];
        logic [31:0] w  [7];
        logic [31:0] r  [7];
        f3[0] = 3'b010; a[0] = 32'h100; w[0] = 32'hDEADBEEF; r[0] = 32'hDEADBEEF;
        f3[1] = 3'b000; a[1] = 32'h103; w[1] = 32'h80123456; r[1] = 32'hFFFFFF80;
        f3[2] = 3'b100; a[2] = 32'h103; w[2] = 32'h80123456; r[2] = 32'h00000080;
        f3[3] = 3'b001; a[3] = 32'h102; w[3] = 32'h80011234; r[3] = 32'hFFFF8001;
        f3[4] = 3'b101; a[4] = 32'h100; w[4] = 32'h1234ABCD; r[4] = 32'h0000ABCD;
        f3[5] = 3'b000; a[5] = 32'h101; w[5] = 32'h00007F00; r[5] = 32'h0000007F;
        f3[6] = 3'b001; a[6] = 32'h100; w[6] = 32'h0000FFFE; r[6] = 32'hFFFFFFFE;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({r[i], 1'b0, 1'b0});
            launch(1'b0, f3[i], a[i], 32'h0);
            vectors++;
            if (mem_req !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0 ||
                mem_addr !== {a[i][31:2], 2'b00}) begin
                miscompares++;
                $display("FAIL load_req[%0d]: req=%b busy=%b we=%b addr=%h, want 1 1 0 %h",
                         i, mem_req, busy, mem_we, mem_addr, {a[i][31:2], 2'b00});
            end
            mem_ack = 1'b1; mem_rdata = w[i];
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 32'hA5A5A5A5;
            vectors++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL load_latency[%0d]: done=%b busy=%b, want 1 0", i, done, busy);
            end
            @(posedge clk); #1;
        end
        // Wait states: request must hold steady until acknowledged.
        exp_q.push_back({32'h0BADF00D, 1'b0, 1'b0});
        launch(1'b0, 3'b010, 32'h300, 32'h0);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h300 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_hold[%0d]: req=%b addr=%h done=%b, want 1 00000300 0",
                         k, mem_req, mem_addr, done);
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stores();
        logic [2:0]  f3 [5];
        logic [31:0] a  [5];
        logic [31:0] wd [5];
        logic [31:0] ea [5];
        logic [31:0] ew [5];
        logic [3:0]  eb [5];
        f3[0] = 3'b000; a[0] = 32'h201; wd[0] = 32'h12345678;
        ea[0] = 32'h200; ew[0] = 32'h78787878; eb[0] = 4'b0010;
        f3[1] = 3'b001; a[1] = 32'h202; wd[1] = 32'h12345678;
        ea[1] = 32'h200; ew[1] = 32'h56785678; eb[1] = 4'b1100;
        f3[2] = 3'b001; a[2] = 32'h200; wd[2] = 32'h12345678;
        ea[2] = 32'h200; ew[2] = 32'h56785678; eb[2] = 4'b0011;
        f3[3] = 3'b010; a[3] = 32'h204; wd[3] = 32'h12345678;
        ea[3] = 32'h204; ew[3] = 32'h12345678; eb[3] = 4'b1111;
        f3[4] = 3'b000; a[4] = 32'h203; wd[4] = 32'hAABBCCDD;
        ea[4] = 32'h200; ew[4] = 32'hDDDDDDDD; eb[4] = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({32'h0, 1'b0, 1'b0});
            launch(1'b1, f3[i], a[i], wd[i]);
            vectors++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ea[i] ||
                mem_wdata !== ew[i] || mem_be !== eb[i]) begin
                miscompares++;
                $display("FAIL store_bus[%0d]: req=%b we=%b addr=%h wdata=%h be=%b, want 1 1 %h %h %b",
                         i, mem_req, mem_we, mem_addr, mem_wdata, mem_be, ea[i], ew[i], eb[i]);
            end
            mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            vectors++;
            if (done !== 1'b1) begin
                miscompares++;
                $display("FAIL store_latency[%0d]: done=%b, want 1", i, done);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_errors();
        logic [2:0]  f3 [7];
        logic        st [7];
        logic [31:0] a  [7];
        logic        em [7];
        logic        ef [7];
        f3[0] = 3'b010; st[0] = 1'b0; a[0] = 32'h102; em[0] = 1'b1; ef[0] = 1'b0;
        f3[1] = 3'b011; st[1] = 1'b0; a[1] = 32'h100; em[1] = 1'b0; ef[1] = 1'b1;
        f3[2] = 3'b001; st[2] = 1'b0; a[2] = 32'h101; em[2] = 1'b1; ef[2] = 1'b0;
        f3[3] = 3'b101; st[3] = 1'b0; a[3] = 32'h103; em[3] = 1'b1; ef[3] = 1'b0;
        f3[4] = 3'b100; st[4] = 1'b1; a[4] = 32'h100; em[4] = 1'b0; ef[4] = 1'b1;
        f3[5] = 3'b011; st[5] = 1'b0; a[5] = 32'h101; em[5] = 1'b0; ef[5] = 1'b1;
        f3[6] = 3'b010; st[6] = 1'b1; a[6] = 32'h206; em[6] = 1'b1; ef[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            // Leave a nonzero result in place so a zeroed rdata is meaningful.
            exp_q.push_back({32'h11223344, 1'b0, 1'b0});
            launch(1'b0, 3'b010, 32'h40, 32'h0);
            mem_ack = 1'b1; mem_rdata = 32'h11223344;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            @(posedge clk); #1;
            exp_q.push_back({32'h0, em[i], ef[i]});
            launch(st[i], f3[i], a[i], 32'hCAFEBABE);
            vectors++;
            if (done !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL error_path[%0d]: done=%b req=%b busy=%b, want 1 0 0",
                         i, done, mem_req, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        int n;
        exp_q.push_back({32'h0, 1'b0, 1'b1});
        launch(1'b0, 3'b010, 32'h400, 32'h0);
        n = 0;
        while (mem_req === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        vectors++;
        if (n != 64) begin
            miscompares++;
            $display("FAIL timeout_len: req held %0d cycles, want 64", n);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_done: done=%b, want 1", done);
        end
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (mem_req !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL late_ack[%0d]: req=%b busy=%b, want 0 0", k, mem_req, busy);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        launch(1'b0, 3'b010, 32'h500, 32'h0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: req=%b busy=%b, want 0 0", mem_req, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back({32'h000000BE, 1'b0, 1'b0});
        launch(1'b0, 3'b100, 32'h502, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h12BE3456;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_op: done=%b, want 1", done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_q.push_back({32'hCAFEF00D, 1'b0, 1'b0});
        launch(1'b0, 3'b010, 32'h600, 32'h0);
        // start while busy and while completing must be ignored.
        start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h700; wdata = 32'h99;
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_done: done=%b, want 1", done);
        end
        @(posedge clk); #1;
        start = 1'b0; is_store = 1'b0; addr = 32'h0; wdata = 32'h0;
        vectors++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_start: req=%b busy=%b, want 0 0", mem_req, busy);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({32'h0, 1'b0, 1'b0});
            launch(1'b1, 3'b000, 32'h800 + 32'(i), 32'h000000C3);
            vectors++;
            if (mem_be !== (4'b0001 << i) || mem_wdata !== 32'hC3C3C3C3) begin
                miscompares++;
                $display("FAIL b2b_store[%0d]: be=%b wdata=%h, want %b C3C3C3C3",
                         i, mem_be, mem_wdata, 4'b0001 << i);
            end
            mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b0;
        addr = 32'b0; wdata = 32'b0; mem_ack = 1'b0; mem_rdata = 32'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_loads();
        test_stores();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_results: %0d completions never arrived, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
